regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised two-read/one-write general-purpose register file for the pipelined CPU, successor to the single-cycle register file. It adds configurable data width and depth, a configurable hardwired-zero register, and a per-register pending-write scoreboard. The scoreboard lets decode detect RAW hazards against in-flight instructions. It sits between decode (reads, issue) and writeback (write, scoreboard clear).

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W (derived localparam, not overridable)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never pending; 0 = register 0 is an ordinary register

Ports:
clk  input  1  clock; all state updates on rising edge
clrn  input  1  reset, synchronous, active-low; sampled on rising edge of clk
rna  input  ADDR_W  read port A address
rnb  input  ADDR_W  read port B address
qa  output  DATA_W  read port A data, combinational
qb  output  DATA_W  read port B data, combinational
we  input  1  writeback write enable
wn  input  ADDR_W  writeback destination
d  input  DATA_W  writeback data
iss  input  1  decode issues an instruction that writes a register
iss_rd  input  ADDR_W  destination of issuing instruction
busy_a  output  1  register rna has a pending write
busy_b  output  1  register rnb has a pending write
busy_rd  output  1  register iss_rd has a pending write (WAW check)

Behaviour:
- State: array reg[0..2**ADDR_W-1] of DATA_W bits; pend[0..2**ADDR_W-1] of 1 bit.
- Reset, clrn==0 at posedge clk:
  - All registers and all pend bits are cleared in that single edge.
  - We and iss are ignored on that edge.
  - After reset: qa=qb=0, busy_a=busy_b=busy_rd=0.
- Reset is synchronous only. A clrn low that deasserts before a clock edge has no effect.
- Write: at posedge with clrn==1 and we==1, reg[wn] <= d.
  - Suppressed when ZERO_REG==1 and wn==0.
- Read:
  - qa = reg[rna], combinational, zero-latency.
  - When ZERO_REG==1 and rna==0, qa=0. Same rules for qb/rnb.
- Scoreboard update at posedge with clrn==1, evaluated per register index r:
  - set if iss==1 and iss_rd==r.
  - clr if we==1 and wn==r.
  - pend[r] next = set ? 1 : (clr ? 0 : pend[r]).
  - Issue wins over writeback to the same register in the same cycle, because the issuing instruction is younger.
  - Writeback to a non-pending register is legal: data is written and pend stays 0.
  - Issue to an already-pending register is legal: pend stays 1. Decode is responsible for stalling on busy_rd if WAW ordering matters.
- ZERO_REG==1: pend[0] is held at 0. busy_* for address 0 is always 0.
- Busy outputs are combinational from pend and the addresses, i.e. they reflect state before the current edge.
  - busy_a = pend[rna], with the bypass exception under the optional feature.
  - busy_b and busy_rd follow the same pattern.
- Simultaneous write and read of the same register, without the optional feature: read returns the old value; the new value is visible from the next cycle.
- Address arithmetic: addresses are unsigned and always in range (depth = 2**ADDR_W); no out-of-range case exists.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined:
  - Write-through forwarding. If we==1 and wn==rna (excluding reg 0 when ZERO_REG==1), qa=d in the same cycle and busy_a=0. Same for port B.
  - busy_rd is not bypassed.
  - Decode can then consume writeback results without a one-cycle bubble.
- Not defined:
  - qa/qb return stored contents only.
  - busy_a/busy_b are pend bits only; a register being written this cycle still reports busy.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then hold clrn=0 one edge, rna=5 -> qa=0 and busy_a=0 after that edge. Clrn pulse low between edges -> r5 unchanged.
- Write/read: we=1, wn=3, d=0x12345678; next cycle rna=3, rnb=0 -> qa=0x12345678, qb=0. Write wn=0, d=0xFFFFFFFF with ZERO_REG=1 -> qb stays 0.
- Scoreboard: iss=1, iss_rd=7, then rna=7 -> busy_a=1. Two cycles later we=1, wn=7 -> after edge busy_a=0. Iss_rd=0 -> busy never set.
- Collision: pend[9]=1; same cycle iss=1 iss_rd=9 and we=1 wn=9 d=0xA5 -> reg9=0xA5, busy stays 1.
- Same-cycle read of write target: we=1 wn=4 d=0x55, rna=4, old reg4=0x11 -> with REGFILE_BYPASS_EN qa=0x55, busy_a=0; without it qa=0x11 that cycle and 0x55 the next.
- Parameter sweep: DATA_W=16, ADDR_W=3, ZERO_REG=0 -> write r0=0xBEEF, r7=0x1234 and read back both; iss_rd=0 sets busy.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Bus bundle between decode/writeback and the scoreboarded register file.
// The master side is decode plus writeback. The slave side is regfile_sb.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rna;
  logic [ADDR_W-1:0] rnb;
  logic [DATA_W-1:0] qa;
  logic [DATA_W-1:0] qb;
  logic              we;
  logic [ADDR_W-1:0] wn;
  logic [DATA_W-1:0] d;
  logic              iss;
  logic [ADDR_W-1:0] iss_rd;
  logic              busy_a;
  logic              busy_b;
  logic              busy_rd;

  modport master (
    output rna, rnb, we, wn, d, iss, iss_rd,
    input  qa, qb, busy_a, busy_b, busy_rd
  );

  modport slave (
    input  rna, rnb, we, wn, d, iss, iss_rd,
    output qa, qb, busy_a, busy_b, busy_rd
  );
endinterface

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a per-register pending-write scoreboard.
// Decode uses busy_a/busy_b to catch RAW hazards and busy_rd to catch WAW hazards.
// Writeback writes data and clears the pending bit.
// Optional macro REGFILE_BYPASS_EN adds write-through forwarding on both read ports.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input logic          clk,
  input logic          clrn,
  regfile_sb_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic              wrEn;
  logic [DATA_W-1:0] qaVal;
  logic [DATA_W-1:0] qbVal;
  logic              busyA;
  logic              busyB;
  logic              busyRd;

  // A write to the hardwired zero register is dropped entirely.
  assign wrEn = bus.we && !(ZERO_REG && (bus.wn == '0));

  // Next scoreboard: a younger issue beats an older writeback to the same register.
  always_comb begin
    pend_d = pend_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (bus.iss && (bus.iss_rd == ADDR_W'(r))) begin
        pend_d[r] = 1'b1;
      end else if (bus.we && (bus.wn == ADDR_W'(r))) begin
        pend_d[r] = 1'b0;
      end
    end
    if (ZERO_REG) begin
      pend_d[0] = 1'b0;
    end
  end

  // Storage and scoreboard update. Reset clears everything and masks we/iss.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      if (wrEn) begin
        regs_q[bus.wn] <= bus.d;
      end
      pend_q <= pend_d;
    end
  end

  // Read port A. Data and busy are taken from state before the edge, with optional forwarding.
  always_comb begin
    qaVal = regs_q[bus.rna];
    busyA = pend_q[bus.rna];
    if (ZERO_REG && (bus.rna == '0)) begin
      qaVal = '0;
      busyA = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    if (wrEn && (bus.wn == bus.rna)) begin
      qaVal = bus.d;
      busyA = 1'b0;
    end
`endif
  end

  // Read port B mirrors port A.
  always_comb begin
    qbVal = regs_q[bus.rnb];
    busyB = pend_q[bus.rnb];
    if (ZERO_REG && (bus.rnb == '0)) begin
      qbVal = '0;
      busyB = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    if (wrEn && (bus.wn == bus.rnb)) begin
      qbVal = bus.d;
      busyB = 1'b0;
    end
`endif
  end

  // WAW check for the issuing destination. It is never forwarded.
  always_comb begin
    busyRd = pend_q[bus.iss_rd];
    if (ZERO_REG && (bus.iss_rd == '0)) begin
      busyRd = 1'b0;
    end
  end

  assign bus.qa      = qaVal;
  assign bus.qb      = qbVal;
  assign bus.busy_a  = busyA;
  assign bus.busy_b  = busyB;
  assign bus.busy_rd = busyRd;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb.
// Unit 0 uses the default configuration (32-bit data, 32 entries, r0 hardwired to zero).
// Unit 1 uses 16-bit data, 8 entries, and r0 as an ordinary register.
// Each vector is held for one cycle. Its expected outputs are queued.
// The monitor checks them at the falling edge.
module tb_regfile_sb;
  localparam bit BYP =
`ifdef REGFILE_BYPASS_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    string       name;
    bit          unit;
    bit          clrnV;
    bit          pulse;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic        iss;
    logic [4:0]  issRd;
    logic [4:0]  mask;
    logic [31:0] eQa;
    logic [31:0] eQb;
    logic        eBa;
    logic        eBb;
    logic        eBr;
  } vec_t;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t sbQ[$];
  vec_t vecs[$];

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ifA ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) ifB ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dutA (
    .clk  (clk),
    .clrn (clrn),
    .bus  (ifA.slave)
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) dutB (
    .clk  (clk),
    .clrn (clrn),
    .bus  (ifB.slave)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input bit unit, input bit clrnV, input bit pulse,
                              input logic [4:0] rna, input logic [4:0] rnb, input logic we,
                              input logic [4:0] wn, input logic [31:0] d, input logic iss,
                              input logic [4:0] issRd, input logic [4:0] mask,
                              input logic [31:0] eQa, input logic [31:0] eQb,
                              input logic eBa, input logic eBb, input logic eBr);
    vec_t v;
    v.name = name; v.unit = unit; v.clrnV = clrnV; v.pulse = pulse;
    v.rna = rna; v.rnb = rnb; v.we = we; v.wn = wn; v.d = d; v.iss = iss; v.issRd = issRd;
    v.mask = mask; v.eQa = eQa; v.eQb = eQb; v.eBa = eBa; v.eBb = eBb; v.eBr = eBr;
    return v;
  endfunction

  task automatic driveIdle();
    ifA.rna = '0; ifA.rnb = '0; ifA.we = 1'b0; ifA.wn = '0; ifA.d = '0;
    ifA.iss = 1'b0; ifA.iss_rd = '0;
    ifB.rna = '0; ifB.rnb = '0; ifB.we = 1'b0; ifB.wn = '0; ifB.d = '0;
    ifB.iss = 1'b0; ifB.iss_rd = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    driveIdle();
    clrn = v.clrnV;
    if (v.unit == 1'b0) begin
      ifA.rna = v.rna; ifA.rnb = v.rnb; ifA.we = v.we; ifA.wn = v.wn; ifA.d = v.d;
      ifA.iss = v.iss; ifA.iss_rd = v.issRd;
    end else begin
      ifB.rna = v.rna[2:0]; ifB.rnb = v.rnb[2:0]; ifB.we = v.we; ifB.wn = v.wn[2:0];
      ifB.d = v.d[15:0]; ifB.iss = v.iss; ifB.iss_rd = v.issRd[2:0];
    end
    if (v.mask != 5'b0) sbQ.push_back(v);
    if (v.pulse) begin
      #1 clrn = 1'b0;
      #2 clrn = 1'b1;
    end
  endtask

  task automatic cmp(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t e);
    logic [31:0] aQa, aQb;
    logic aBa, aBb, aBr;
    if (e.unit == 1'b0) begin
      aQa = ifA.qa; aQb = ifA.qb; aBa = ifA.busy_a; aBb = ifA.busy_b; aBr = ifA.busy_rd;
    end else begin
      aQa = {16'h0, ifB.qa}; aQb = {16'h0, ifB.qb};
      aBa = ifB.busy_a; aBb = ifB.busy_b; aBr = ifB.busy_rd;
    end
    if (e.mask[4]) cmp(e.name, "qa", aQa, e.eQa);
    if (e.mask[3]) cmp(e.name, "qb", aQb, e.eQb);
    if (e.mask[2]) cmp(e.name, "busy_a", {31'b0, aBa}, {31'b0, e.eBa});
    if (e.mask[1]) cmp(e.name, "busy_b", {31'b0, aBb}, {31'b0, e.eBb});
    if (e.mask[0]) cmp(e.name, "busy_rd", {31'b0, aBr}, {31'b0, e.eBr});
  endtask

  // Monitor: pops one expected response per cycle, away from the active edge
  always @(negedge clk) begin
    if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
  end

  initial begin
    // Unit 0: default configuration, r0 hardwired.
    vecs.push_back(mk("reset_state", 0,1,0, 5,7, 0,0,32'h0, 0,3, 5'b11111, 32'h0,32'h0, 0,0,0));
    vecs.push_back(mk("wr_r5_same", 0,1,0, 5,0, 1,5,32'hDEADBEEF, 0,0, 5'b11100,
                      BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 0,0,0));
    vecs.push_back(mk("pre_reset_rd", 0,0,0, 5,0, 1,6,32'h1111, 1,6, 5'b11000,
                      32'hDEADBEEF, 32'h0, 0,0,0));
    vecs.push_back(mk("after_reset", 0,1,0, 5,6, 0,0,32'h0, 0,6, 5'b11111, 32'h0,32'h0, 0,0,0));
    vecs.push_back(mk("wr_r5_again", 0,1,0, 5,0, 1,5,32'hDEADBEEF, 0,0, 5'b00100, 32'h0,32'h0, 0,0,0));
    vecs.push_back(mk("clrn_pulse", 0,1,1, 5,0, 0,0,32'h0, 0,0, 5'b10000, 32'hDEADBEEF,32'h0, 0,0,0));
    vecs.push_back(mk("after_pulse", 0,1,0, 5,0, 0,0,32'h0, 0,0, 5'b10000, 32'hDEADBEEF,32'h0, 0,0,0));
    vecs.push_back(mk("wr_r3", 0,1,0, 3,0, 1,3,32'h12345678, 0,0, 5'b00100, 32'h0,32'h0, 0,0,0));
    vecs.push_back(mk("rd_r3_wr_r0", 0,1,0, 3,0, 1,0,32'hFFFFFFFF, 0,0, 5'b11100,
                      32'h12345678, 32'h0, 0,0,0));
    vecs.push_back(mk("rd_r0", 0,1,0, 0,0, 0,0,32'h0, 0,0, 5'b11110, 32'h0,32'h0, 0,0,0));
    vecs.push_back(mk("iss_r7", 0,1,0, 7,0, 0,0,32'h0, 1,7, 5'b00101, 32'h0,32'h0, 0,0,0));
    vecs.push_back(mk("busy_r7", 0,1,0, 7,7, 0,0,32'h0, 0,7, 5'b00111, 32'h0,32'h0, 1,1,1));
    vecs.push_back(mk("busy_r7_hold", 0,1,0, 7,0, 0,0,32'h0, 0,0, 5'b00100, 32'h0,32'h0, 1,0,0));
    vecs.push_back(mk("wb_r7", 0,1,0, 7,0, 1,7,32'h77, 0,7, 5'b10101,
                      BYP ? 32'h77 : 32'h0, 32'h0, BYP ? 1'b0 : 1'b1, 0, 1));
    vecs.push_back(mk("cleared_r7", 0,1,0, 7,0, 0,0,32'h0, 0,7, 5'b10101, 32'h77,32'h0, 0,0,0));
    vecs.push_back(mk("iss_r0", 0,1,0, 0,0, 0,0,32'h0, 1,0, 5'b00101, 32'h0,32'h0, 0,0,0));
    vecs.push_back(mk("r0_never_busy", 0,1,0, 0,0, 0,0,32'h0, 0,0, 5'b10111, 32'h0,32'h0, 0,0,0));
    vecs.push_back(mk("iss_r9", 0,1,0, 9,0, 0,0,32'h0, 1,9, 5'b00100, 32'h0,32'h0, 0,0,0));
    vecs.push_back(mk("collide_r9", 0,1,0, 9,0, 1,9,32'hA5, 1,9, 5'b10101,
                      BYP ? 32'hA5 : 32'h0, 32'h0, BYP ? 1'b0 : 1'b1, 0, 1));
    vecs.push_back(mk("after_collide", 0,1,0, 9,0, 0,0,32'h0, 0,9, 5'b10101, 32'hA5,32'h0, 1,0,1));
    vecs.push_back(mk("wr_r4_old", 0,1,0, 4,4, 1,4,32'h11, 0,0, 5'b00100, 32'h0,32'h0, 0,0,0));
    vecs.push_back(mk("rw_r4_same", 0,1,0, 4,4, 1,4,32'h55, 0,0, 5'b11110,
                      BYP ? 32'h55 : 32'h11, BYP ? 32'h55 : 32'h11, 0,0,0));
    vecs.push_back(mk("rd_r4_next", 0,1,0, 4,4, 0,0,32'h0, 0,0, 5'b11000, 32'h55,32'h55, 0,0,0));
    // Unit 1: 16-bit data, 3-bit addresses, r0 ordinary.
    vecs.push_back(mk("b_wr_r0", 1,1,0, 0,0, 1,0,32'hBEEF, 0,0, 5'b00100, 32'h0,32'h0, 0,0,0));
    vecs.push_back(mk("b_wr_r7", 1,1,0, 0,7, 1,7,32'h1234, 0,0, 5'b11000,
                      32'hBEEF, BYP ? 32'h1234 : 32'h0, 0,0,0));
    vecs.push_back(mk("b_rd_r0_r7", 1,1,0, 0,7, 0,0,32'h0, 0,0, 5'b11000, 32'hBEEF,32'h1234, 0,0,0));
    vecs.push_back(mk("b_iss_r0", 1,1,0, 0,0, 0,0,32'h0, 1,0, 5'b00101, 32'h0,32'h0, 0,0,0));
    vecs.push_back(mk("b_busy_r0", 1,1,0, 0,0, 0,0,32'h0, 0,0, 5'b00111, 32'h0,32'h0, 1,1,1));
    vecs.push_back(mk("b_wb_r0", 1,1,0, 0,0, 1,0,32'h42, 0,0, 5'b10101,
                      BYP ? 32'h42 : 32'hBEEF, 32'h0, BYP ? 1'b0 : 1'b1, 0, 1));
    vecs.push_back(mk("b_cleared_r0", 1,1,0, 0,0, 0,0,32'h0, 0,0, 5'b10101, 32'h42,32'h0, 0,0,0));

    $display("[TB] starting, bypass=%0d", BYP);
    driveIdle();
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    foreach (vecs[i]) applyStimulus(vecs[i]);

    for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sbQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d pending required=0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
